// File: rtl/move_sort_sequencer_if.sv
// Generator-in / sorted-move-out streams of the move sort sequencer.
// master = sequencer side, slave = producer/consumer side.
interface move_sort_sequencer_if #(
    parameter int W = 16
);
    logic         gen_valid;
    logic [W-1:0] gen_data;
    logic         gen_last;
    logic         gen_end_empty;
    logic         gen_ready;
    logic         mv_valid;
    logic [W-1:0] mv_data;
    logic         mv_last;
    logic         mv_ready;

    modport master (
        input  gen_valid, gen_data, gen_last, gen_end_empty, mv_ready,
        output gen_ready, mv_valid, mv_data, mv_last
    );

    modport slave (
        output gen_valid, gen_data, gen_last, gen_end_empty, mv_ready,
        input  gen_ready, mv_valid, mv_data, mv_last
    );
endinterface

// File: rtl/move_sort_sequencer.sv
// Per-node sequencer around move_sort: load list, sort, stream sorted moves, release sorter.
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 64
`endif

module move_sort_sequencer #(
    parameter int RAM_WIDTH          = 16,
    parameter int MAX_POSITIONS_LOG2 = $clog2(`MAX_POSITIONS),
    parameter int RD_LATENCY         = 2,
    parameter int OBUF_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          list_start,
    input  logic                          list_white_to_move,
    move_sort_sequencer_if.master         io,
    output logic [MAX_POSITIONS_LOG2:0]   move_count,
    output logic                          overflow,
    output logic                          busy,
    output logic                          list_done,
    output logic                          sort_start,
    output logic                          sort_clear,
    output logic                          white_to_move,
    output logic                          ram_wr_addr_init,
    output logic                          ram_wr,
    output logic [RAM_WIDTH-1:0]          ram_wr_data,
    output logic [MAX_POSITIONS_LOG2-1:0] ram_rd_addr,
    input  logic [RAM_WIDTH-1:0]          ram_rd_data,
    input  logic [MAX_POSITIONS_LOG2-1:0] ram_wr_addr,
    input  logic                          sort_complete
);
    localparam int AW = MAX_POSITIONS_LOG2;
    localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int OW = $clog2(OBUF_DEPTH + 1);
    localparam logic [AW:0] CAP = {1'b0, {AW{1'b1}}};

    typedef enum logic [3:0] {
        S_IDLE, S_RECOVER, S_RECOVER_WAIT, S_LOAD, S_SETTLE,
        S_KICK, S_WAIT, S_DRAIN, S_CLEAR, S_CLEAR_WAIT
    } state_t;

    state_t state, state_nx;

    logic [AW:0]           count, rd_addr, pop_cnt;
    logic [RAM_WIDTH-1:0]  obuf [OBUF_DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic [OW-1:0]         occ, in_flight;
    logic [RD_LATENCY:1]   vld_q;
    logic [RD_LATENCY:0]   vld_pipe;
    logic                  accept, rd_issue, push, pop;

    // The SETTLE cycle absorbs the sorter's write-pointer update, so its value is not consumed here.
    logic unused_wr_addr;
    assign unused_wr_addr = ^ram_wr_addr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign accept      = (state == S_LOAD) && io.gen_valid;
    assign ram_wr      = accept && (count < CAP);
    assign ram_wr_data = ram_wr ? io.gen_data : '0;
    assign io.gen_ready = (state == S_LOAD);
    assign busy        = (state != S_IDLE);
    assign move_count  = count;
    assign ram_rd_addr = (state == S_DRAIN) ? rd_addr[AW-1:0] : '0;

    // Reads are throttled so every issued read has a guaranteed buffer slot on landing.
    always_comb begin
        in_flight = '0;
        for (int i = 1; i <= RD_LATENCY; i++) in_flight = in_flight + OW'(vld_pipe[i]);
    end

    assign rd_issue = (state == S_DRAIN) && (rd_addr < count) &&
                      (({1'b0, occ} + {1'b0, in_flight}) < (OW+1)'(OBUF_DEPTH));
    assign vld_pipe = {vld_q, rd_issue};
    assign push     = vld_pipe[RD_LATENCY];

    assign io.mv_valid = (occ != '0);
    assign io.mv_data  = io.mv_valid ? obuf[rptr] : '0;
    assign io.mv_last  = io.mv_valid && (pop_cnt == count - 1'b1);
    assign pop         = io.mv_valid && io.mv_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            count         <= '0;
            overflow      <= 1'b0;
            white_to_move <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && state_nx == S_LOAD) begin
                count         <= '0;
                overflow      <= 1'b0;
                white_to_move <= list_white_to_move;
            end else if (accept) begin
                if (count < CAP) count <= count + 1'b1;
                else             overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr <= '0;
            pop_cnt <= '0;
            wptr    <= '0;
            rptr    <= '0;
            occ     <= '0;
            vld_q   <= '0;
        end else if (state != S_DRAIN) begin
            rd_addr <= '0;
            pop_cnt <= '0;
            wptr    <= '0;
            rptr    <= '0;
            occ     <= '0;
            vld_q   <= '0;
        end else begin
            vld_q <= vld_pipe[RD_LATENCY-1:0];
            if (rd_issue) rd_addr <= rd_addr + 1'b1;
            if (push)     wptr <= nxt(wptr);
            if (pop) begin
                rptr    <= nxt(rptr);
                pop_cnt <= pop_cnt + 1'b1;
            end
            occ <= occ + OW'(push) - OW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) obuf[wptr] <= ram_rd_data;
    end

    always_comb begin
        state_nx         = state;
        ram_wr_addr_init = 1'b0;
        sort_start       = 1'b0;
        sort_clear       = 1'b0;
        list_done        = 1'b0;
        case (state)
            // A sorter left complete (e.g. reset mid-sort) is released before any new list.
            S_IDLE: begin
                if (sort_complete) state_nx = S_RECOVER;
                else if (list_start) begin
                    ram_wr_addr_init = 1'b1;
                    state_nx         = S_LOAD;
                end
            end
            S_RECOVER: begin
                sort_clear = 1'b1;
                state_nx   = S_RECOVER_WAIT;
            end
            S_RECOVER_WAIT: if (!sort_complete) state_nx = S_IDLE;
            S_LOAD: if ((io.gen_valid && io.gen_last) || io.gen_end_empty) state_nx = S_SETTLE;
            S_SETTLE: state_nx = S_KICK;
            S_KICK: begin
                sort_start = 1'b1;
                state_nx   = S_WAIT;
            end
            S_WAIT: if (sort_complete) state_nx = S_DRAIN;
            S_DRAIN: if (count == '0 || (pop && io.mv_last)) state_nx = S_CLEAR;
            S_CLEAR: begin
                sort_clear = 1'b1;
                state_nx   = S_CLEAR_WAIT;
            end
            S_CLEAR_WAIT: begin
                if (!sort_complete) begin
                    list_done = 1'b1;
                    state_nx  = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_move_sort_sequencer.sv
// Bench for move_sort_sequencer with a behavioural move_sort stand-in and a rank-based reference.
module tb_move_sort_sequencer;
    localparam int W = 16, L = 6, CAP = 63;

    logic clk = 1'b0, reset_n = 1'b0;
    always #5 clk = ~clk;

    logic list_start, list_white;
    move_sort_sequencer_if #(.W(W)) io();
    logic [L:0]   move_count;
    logic         overflow, busy, list_done, sort_start, sort_clear, white_to_move;
    logic         ram_wr_addr_init, ram_wr, sort_complete;
    logic [W-1:0] ram_wr_data, ram_rd_data;
    logic [L-1:0] ram_rd_addr, ram_wr_addr;

    move_sort_sequencer #(.RAM_WIDTH(W), .MAX_POSITIONS_LOG2(L), .RD_LATENCY(2), .OBUF_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .list_start(list_start), .list_white_to_move(list_white),
        .io(io.master), .move_count(move_count), .overflow(overflow), .busy(busy),
        .list_done(list_done), .sort_start(sort_start), .sort_clear(sort_clear),
        .white_to_move(white_to_move), .ram_wr_addr_init(ram_wr_addr_init), .ram_wr(ram_wr),
        .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .ram_wr_addr(ram_wr_addr), .sort_complete(sort_complete));

    // Record: [15] capture, [14:8] id, [7:0] signed eval. Captures first, then eval by side.
    function automatic bit better(input logic [W-1:0] a, input logic [W-1:0] b, input bit w);
        logic signed [7:0] ea, eb;
        ea = a[7:0];
        eb = b[7:0];
        if (a[15] != b[15]) return a[15];
        return w ? (ea > eb) : (ea < eb);
    endfunction

    // Sorter stand-in: write pointer, edge-detected start, bubble sort, 2-cycle read.
    logic [W-1:0] mem [64];
    logic [W-1:0] srt [64];
    logic [L-1:0] s_wr_addr = '0;
    logic         s_complete = 1'b0, ss_prev = 1'b0, s_white = 1'b0;
    logic [W-1:0] rd_p1 = '0, rd_p2 = '0;
    int           s_cd = 0, ss_cycles = 0, ld_pulses = 0, sc_pulses = 0;
    assign ram_wr_addr   = s_wr_addr;
    assign sort_complete = s_complete;
    assign ram_rd_data   = rd_p2;

    always @(posedge clk) begin
        ss_prev <= sort_start;
        if (sort_start) ss_cycles <= ss_cycles + 1;
        if (list_done)  ld_pulses <= ld_pulses + 1;
        if (sort_clear) sc_pulses <= sc_pulses + 1;
        if (ram_wr_addr_init) s_wr_addr <= '0;
        else if (ram_wr) begin
            mem[s_wr_addr] <= ram_wr_data;
            s_wr_addr      <= s_wr_addr + 1'b1;
        end
        rd_p1 <= mem[ram_rd_addr];
        rd_p2 <= rd_p1;
        if (sort_clear) begin
            s_complete <= 1'b0;
            s_cd       <= 0;
        end else if (sort_start && !ss_prev) begin
            s_white <= white_to_move;
            if (s_wr_addr <= 1) s_complete <= 1'b1;
            else                s_cd <= int'(s_wr_addr) + 2;
        end else if (s_cd > 0) begin
            s_cd <= s_cd - 1;
            if (s_cd == 1) begin
                for (int i = 0; i < 64; i++) srt[i] = mem[i];
                for (int p = 0; p < int'(s_wr_addr); p++)
                    for (int j = 0; j < int'(s_wr_addr) - 1 - p; j++)
                        if (better(srt[j+1], srt[j], s_white)) begin
                            logic [W-1:0] t;
                            t = srt[j]; srt[j] = srt[j+1]; srt[j+1] = t;
                        end
                for (int i = 0; i < 64; i++) mem[i] <= srt[i];
                s_complete <= 1'b1;
            end
        end
    end

    int n_chk = 0, n_fail = 0;
    logic [W-1:0] moves [80];
    logic [W-1:0] expv [80];
    int exp_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {21'd0, io.gen_ready, io.mv_valid, io.mv_last, overflow, busy, list_done,
                            sort_start, sort_clear, white_to_move, ram_wr_addr_init, ram_wr}, 32'd0);
        chk({tag, "_data"}, {io.mv_data, ram_wr_data}, 32'd0);
        chk({tag, "_count"}, 32'(move_count), 32'd0);
    endtask

    // Expected position = number of strictly better moves + equal-key moves offered earlier.
    task automatic make_expected(input bit w, input int n);
        int m, pos;
        m = (n > CAP) ? CAP : n;
        for (int i = 0; i < m; i++) begin
            pos = 0;
            for (int j = 0; j < m; j++)
                if (better(moves[j], moves[i], w) ||
                    (j < i && !better(moves[i], moves[j], w) && !better(moves[j], moves[i], w))) pos++;
            expv[pos] = moves[i];
        end
        exp_n = m;
    endtask

    task automatic rand_moves(input int n);
        for (int i = 0; i < n; i++)
            moves[i] = {($urandom_range(0, 7) == 0), 7'(i), 8'($urandom)};
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((busy || sort_complete) && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("idle_wait", {30'd0, busy, sort_complete}, 32'd0);
    endtask

    task automatic start_and_load(input bit w, input int n);
        wait_idle();
        make_expected(w, n);
        @(negedge clk);
        list_start = 1'b1;
        list_white = w;
        @(negedge clk);
        list_start = 1'b0;
        chk("busy_load", 32'(busy), 32'd1);
        chk("white_latch", 32'(white_to_move), 32'(w));
        if (n == 0) begin
            io.gen_end_empty = 1'b1;
            @(negedge clk);
            io.gen_end_empty = 1'b0;
        end else begin
            for (int i = 0; i < n; i++) begin
                io.gen_valid = 1'b1;
                io.gen_data  = moves[i];
                io.gen_last  = (i == n - 1);
                chk("gen_ready", 32'(io.gen_ready), 32'd1);
                @(negedge clk);
            end
            io.gen_valid = 1'b0;
            io.gen_last  = 1'b0;
        end
        chk("move_count", 32'(move_count), 32'(exp_n));
        chk("overflow", 32'(overflow), 32'(n > CAP));
    endtask

    task automatic drain_and_check(input bit rnd, input bit poke, output int done_cyc, output int span);
        int k, cyc, ld0, ss0, first_pop, last_pop;
        bit stalled, got_done;
        logic [W-1:0] held;
        ld0 = ld_pulses; ss0 = ss_cycles;
        k = 0; cyc = 0; stalled = 0; got_done = 0; held = '0; first_pop = -1; last_pop = -1;
        while (!got_done && cyc < 300 + 8 * exp_n) begin
            if (stalled) begin
                chk("stall_valid", 32'(io.mv_valid), 32'd1);
                chk("stall_data", 32'(io.mv_data), 32'(held));
            end
            if (list_done) got_done = 1;
            io.mv_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke) begin
                io.gen_valid = 1'($urandom_range(0, 1));
                io.gen_data  = 16'($urandom);
                list_start   = (cyc == 5);
                chk("gen_ready_off", 32'(io.gen_ready), 32'd0);
            end
            stalled = 0;
            if (io.mv_valid) begin
                if (io.mv_ready) begin
                    chk("beat_in_range", 32'(k < exp_n), 32'd1);
                    if (k < exp_n) begin
                        chk("mv_data", 32'(io.mv_data), 32'(expv[k]));
                        chk("mv_last", 32'(io.mv_last), 32'(k == exp_n - 1));
                    end
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                    k++;
                end else begin
                    stalled = 1;
                    held    = io.mv_data;
                end
            end
            @(negedge clk);
            cyc++;
        end
        io.mv_ready = 1'b0; io.gen_valid = 1'b0; list_start = 1'b0;
        chk("list_done_seen", 32'(got_done), 32'd1);
        chk("drained", 32'(k), 32'(exp_n));
        @(negedge clk);
        chk("list_done_once", 32'(ld_pulses - ld0), 32'd1);
        chk("sort_start_1cyc", 32'(ss_cycles - ss0), 32'd1);
        chk("idle_after", 32'(busy), 32'd0);
        chk("sorter_released", 32'(sort_complete), 32'd0);
        done_cyc = cyc;
        span = last_pop - first_pop;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ev[5];
        int dc, sp, c, sc0;
        ev = '{3, -1, 9, 0, 9};
        list_start = 1'b0; list_white = 1'b0;
        io.gen_valid = 1'b0; io.gen_data = '0; io.gen_last = 1'b0;
        io.gen_end_empty = 1'b0; io.mv_ready = 1'b0;
        @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_zero("post_reset");

        // White, 5 moves: 9(id3), 9(id5), 3(id1), 0(id4), -1(id2), back to back.
        for (int i = 0; i < 5; i++) moves[i] = {1'b0, 7'(i + 1), 8'(ev[i])};
        start_and_load(1'b1, 5);
        expv[0] = {1'b0, 7'd3, 8'd9};  expv[1] = {1'b0, 7'd5, 8'd9};
        expv[2] = {1'b0, 7'd1, 8'd3};  expv[3] = {1'b0, 7'd4, 8'd0};
        expv[4] = {1'b0, 7'd2, 8'hFF};
        drain_and_check(1'b0, 1'b0, dc, sp);
        chk("drain_rate_white", 32'(sp), 32'd4);

        // Black, same list: -1, 0, 3, 9(id3), 9(id5).
        start_and_load(1'b0, 5);
        expv[0] = {1'b0, 7'd2, 8'hFF}; expv[1] = {1'b0, 7'd4, 8'd0};
        expv[2] = {1'b0, 7'd1, 8'd3};  expv[3] = {1'b0, 7'd3, 8'd9};
        expv[4] = {1'b0, 7'd5, 8'd9};
        drain_and_check(1'b0, 1'b0, dc, sp);
        chk("drain_rate_black", 32'(sp), 32'd4);

        // Capture with eval -50 leads for both sides.
        moves[5] = {1'b1, 7'd6, 8'hCE};
        start_and_load(1'b1, 6);
        chk("capture_first_w", 32'(expv[0]), 32'h86CE);
        drain_and_check(1'b0, 1'b0, dc, sp);
        start_and_load(1'b0, 6);
        drain_and_check(1'b0, 1'b0, dc, sp);

        // Empty list.
        start_and_load(1'b1, 0);
        drain_and_check(1'b0, 1'b0, dc, sp);
        chk("empty_done_fast", 32'(dc <= 10), 32'd1);

        // 40 random moves, random back-pressure, stray inputs during drain.
        rand_moves(40);
        start_and_load(1'($urandom_range(0, 1)), 40);
        drain_and_check(1'b1, 1'b1, dc, sp);

        // Over capacity.
        rand_moves(67);
        start_and_load(1'b1, 67);
        drain_and_check(1'b1, 1'b0, dc, sp);

        // Reset while the sorter is busy, then recovery.
        rand_moves(20);
        start_and_load(1'b0, 20);
        c = 0;
        while (dut.busy && !sort_start && c < 20) begin @(negedge clk); c++; end
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_zero("reset_mid");
        chk("sorter_still_busy", 32'(sort_complete), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        sc0 = sc_pulses;
        @(negedge clk);
        check_zero("after_release");
        c = 0;
        while (!sort_complete && c < 100) begin @(negedge clk); c++; end
        chk("sorter_completed", 32'(sort_complete), 32'd1);
        wait_idle();
        chk("recover_clear", 32'(sc_pulses - sc0), 32'd1);
        rand_moves(12);
        start_and_load(1'b1, 12);
        drain_and_check(1'b1, 1'b0, dc, sp);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
